axi4_master: RTL and testbench
==============================

Name: axi4_master

Overview:
Single-beat AXI4 initiator that turns one command from a local request port into one AXI4 write (AW+W+B) or read (AR+R) transaction. It returns the AXI response and any read data on a local response port. It is the driving end for the team's single-beat AXI4 slave memory and is used by the bus bench and the core's uncached load/store path. One transaction is outstanding at a time; there are no bursts.

Parameters:
ADDR_W, 32, width of cmd_addr, aw_addr, ar_addr
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transaction address
cmd_wdata  in  DATA_W  write data (ignored for reads)
cmd_wstrb  in  DATA_W/8  write byte strobes (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_resp  out  2  AXI resp code (from B or R)
aw_addr  out  ADDR_W  write address
aw_len  out  8  constant 0 (single beat)
aw_valid  out  1
aw_ready  in  1
w_data  out  DATA_W
w_strb  out  DATA_W/8
w_valid  out  1
w_ready  in  1
b_resp  in  2
b_valid  in  1
b_ready  out  1
ar_addr  out  ADDR_W  read address
ar_len  out  8  constant 0
ar_valid  out  1
ar_ready  in  1
r_data  in  DATA_W
r_resp  in  2
r_valid  in  1
r_ready  out  1

Behaviour:
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- Reset: state=IDLE. aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid are 0. rsp_rdata=0, rsp_resp=0. aw_addr, ar_addr, w_data, w_strb are 0. A reset mid-transaction abandons the transaction; no valid is high in the cycle after reset.
- cmd_ready = (state==IDLE). This is a registered-state decode and has no combinational path from cmd_valid.
- IDLE, on cmd_valid: latch addr, wdata and wstrb into the AW/AR/W output registers.
  - If cmd_write: go to WR_REQ and assert aw_valid and w_valid together on the next cycle.
  - Otherwise: go to RD_REQ and assert ar_valid on the next cycle.
- WR_REQ: AW and W complete independently.
  - aw_valid drops the cycle after aw_valid&&aw_ready.
  - w_valid drops the cycle after w_valid&&w_ready.
  - Either order is legal, as is the same cycle. Per-channel done flags track completion.
  - Go to WR_RESP once both are done, including when both complete in the same cycle.
- WR_RESP: b_ready=1. On b_valid, capture b_resp into rsp_resp, set rsp_rdata=0, drop b_ready and go to RSP.
- RD_REQ: hold ar_valid until ar_ready, then go to RD_DATA.
- RD_DATA: r_ready=1. On r_valid, capture r_data and r_resp into rsp_rdata and rsp_resp, drop r_ready and go to RSP.
- RSP: rsp_valid=1, with rsp_rdata and rsp_resp held stable until rsp_ready. On rsp_ready, rsp_valid=0 and the state returns to IDLE.
- AXI stability: every *_valid, once high, stays high with payload unchanged until its ready. Valid never depends combinationally on ready.
- b_ready is low outside WR_RESP and r_ready is low outside RD_DATA. Stray b_valid or r_valid in other states is ignored.
- aw_len and ar_len are always 0. cmd_wstrb=0 still issues a legal write. Addresses pass through unmodified with no alignment check.
- Minimum latency with all readys and valids immediate:
  - command accepted at edge N; bus request at N+1; B/R handshake at N+2; rsp_valid high at N+3.
  - With rsp_ready=1, cmd_ready is high again at N+4.
- Error responses (SLVERR=2, DECERR=3) pass through unchanged. No retry.

Test Plan:
- Write 0xDEADBEEF to addr 0x10, wstrb 0xF, all readys tied 1, b_resp=0 -> aw_addr=0x10, w_data=0xDEADBEEF, aw_len=0; rsp_valid at accept+3 with rsp_resp=0, rsp_rdata=0.
- Read addr 0x10; slave gives ar_ready after 2 cycles and r_data=0xDEADBEEF, r_resp=0 after 3 more -> ar_valid held stable 3 cycles; rsp_rdata=0xDEADBEEF; cmd_ready low throughout.
- Write with w_ready 4 cycles before aw_ready, then the reverse order -> w_valid/aw_valid each drop independently; b_ready rises only after the later handshake; one response each.
- b_resp=2 on a write, r_resp=3 on a read -> rsp_resp=2 and 3 respectively; FSM returns to IDLE.
- rsp_ready held low 5 cycles while cmd_valid=1 -> rsp stable, cmd_ready=0, no new AW/AR; command accepted the cycle after rsp_ready.
- Assert rst in WR_REQ with aw_valid=1 -> next cycle all valids/readys 0, cmd_ready=1; a subsequent read completes normally.

Source files
------------

// File: rtl/axi4_master.sv
// ============================================================================
// axi4_master
// ----------------------------------------------------------------------------
// Single-beat AXI4 initiator. One command from the local request port becomes
// one AXI4 write (AW + W + B) or one AXI4 read (AR + R). The AXI response code,
// and the read data for reads, come back on the local response port. Only one
// transaction is in flight at a time and there are no bursts (len is always 0).
//
// Ports
//   clk, rst                  clock (rising edge) and synchronous active-high
//                             reset
//   cmd_valid / cmd_ready     local command handshake
//   cmd_write                 1 = write, 0 = read
//   cmd_addr                  transaction address, passed through unmodified
//   cmd_wdata / cmd_wstrb     write data and byte strobes (ignored for reads)
//   rsp_valid / rsp_ready     local response handshake
//   rsp_rdata                 read data (0 for writes)
//   rsp_resp                  AXI response code taken from B or R
//   aw_* / w_* / b_*          AXI4 write address, write data and write
//                             response channels
//   ar_* / r_*                AXI4 read address and read data channels
//
// Every AXI valid and every local ready/valid is a decode of registered state.
// No output depends combinationally on an input, so the bus-side handshakes
// cannot form combinational loops with the slave.
// ============================================================================
module axi4_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // Local command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    // Local response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    // AXI4 write address channel
    output logic [ADDR_W-1:0]     aw_addr,
    output logic [7:0]            aw_len,
    output logic                  aw_valid,
    input  logic                  aw_ready,

    // AXI4 write data channel
    output logic [DATA_W-1:0]     w_data,
    output logic [DATA_W/8-1:0]   w_strb,
    output logic                  w_valid,
    input  logic                  w_ready,

    // AXI4 write response channel
    input  logic [1:0]            b_resp,
    input  logic                  b_valid,
    output logic                  b_ready,

    // AXI4 read address channel
    output logic [ADDR_W-1:0]     ar_addr,
    output logic [7:0]            ar_len,
    output logic                  ar_valid,
    input  logic                  ar_ready,

    // AXI4 read data channel
    input  logic [DATA_W-1:0]     r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_valid,
    output logic                  r_ready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic                r_aw_done;     // AW handshake seen in this write
    logic                r_w_done;      // W handshake seen in this write
    logic [ADDR_W-1:0]   r_addr;        // shared by AW and AR; only one is used
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [1:0]          r_rsp_resp;

    // Next-state values produced by the combinational process
    state_t              w_state_next;
    logic                w_aw_done_next;
    logic                w_w_done_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [DATA_W-1:0]   w_wdata_next;
    logic [STRB_W-1:0]   w_wstrb_next;
    logic [DATA_W-1:0]   w_rsp_rdata_next;
    logic [1:0]          w_rsp_resp_next;

    // Handshake qualifiers; each uses the registered valid/ready we drive
    logic                w_aw_fire;
    logic                w_w_fire;
    logic                w_b_fire;
    logic                w_ar_fire;
    logic                w_r_fire;
    logic                w_rsp_fire;

    // ------------------------------------------------------------------------
    // Output decodes (all from registers)
    // ------------------------------------------------------------------------
    assign cmd_ready = (r_state == IDLE);

    // AW and W are presented together on entry to WR_REQ and then each one
    // retires on its own handshake, so the slave may take them in any order.
    assign aw_valid  = (r_state == WR_REQ) && !r_aw_done;
    assign w_valid   = (r_state == WR_REQ) && !r_w_done;
    assign b_ready   = (r_state == WR_RESP);
    assign ar_valid  = (r_state == RD_REQ);
    assign r_ready   = (r_state == RD_DATA);
    assign rsp_valid = (r_state == RSP);

    assign aw_addr   = r_addr;
    assign ar_addr   = r_addr;
    assign aw_len    = 8'd0;
    assign ar_len    = 8'd0;
    assign w_data    = r_wdata;
    assign w_strb    = r_wstrb;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;

    assign w_aw_fire  = aw_valid  && aw_ready;
    assign w_w_fire   = w_valid   && w_ready;
    assign w_b_fire   = b_ready   && b_valid;
    assign w_ar_fire  = ar_valid  && ar_ready;
    assign w_r_fire   = r_ready   && r_valid;
    assign w_rsp_fire = rsp_valid && rsp_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            r_state     <= w_state_next;
            r_aw_done   <= w_aw_done_next;
            r_w_done    <= w_w_done_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_wstrb     <= w_wstrb_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_resp  <= w_rsp_resp_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Hold everything by default
        w_state_next     = r_state;
        w_aw_done_next   = r_aw_done;
        w_w_done_next    = r_w_done;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_wstrb_next     = r_wstrb;
        w_rsp_rdata_next = r_rsp_rdata;
        w_rsp_resp_next  = r_rsp_resp;

        unique case (r_state)
            IDLE: begin
                w_aw_done_next = 1'b0;
                w_w_done_next  = 1'b0;
                if (cmd_valid) begin
                    // Payload is captured here so the AXI payload is stable
                    // from the first cycle its valid is high.
                    w_addr_next  = cmd_addr;
                    w_wdata_next = cmd_wdata;
                    w_wstrb_next = cmd_wstrb;
                    w_state_next = cmd_write ? WR_REQ : RD_REQ;
                end
            end

            WR_REQ: begin
                // Fold this cycle's handshakes into the done flags before the
                // exit test so that simultaneous AW/W completion moves on at
                // once instead of idling a cycle.
                w_aw_done_next = r_aw_done || w_aw_fire;
                w_w_done_next  = r_w_done  || w_w_fire;
                if (w_aw_done_next && w_w_done_next) begin
                    w_state_next = WR_RESP;
                end
            end

            WR_RESP: begin
                if (w_b_fire) begin
                    w_rsp_resp_next  = b_resp;
                    w_rsp_rdata_next = '0;
                    w_state_next     = RSP;
                end
            end

            RD_REQ: begin
                if (w_ar_fire) begin
                    w_state_next = RD_DATA;
                end
            end

            RD_DATA: begin
                if (w_r_fire) begin
                    w_rsp_rdata_next = r_data;
                    w_rsp_resp_next  = r_resp;
                    w_state_next     = RSP;
                end
            end

            RSP: begin
                // Response payload is held in its registers until consumed.
                if (w_rsp_fire) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_master.sv
// ============================================================================
// tb_axi4_master
// ----------------------------------------------------------------------------
// Directed bench for axi4_master. The bench plays the AXI slave and the local
// requester by driving handshake inputs directly, one cycle at a time, and
// compares DUT outputs against hand-computed values.
// ============================================================================
module tb_axi4_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_wdata;
    logic [3:0]         cmd_wstrb;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_rdata;
    logic [1:0]         rsp_resp;
    logic [ADDR_W-1:0]  aw_addr;
    logic [7:0]         aw_len;
    logic               aw_valid;
    logic               aw_ready;
    logic [DATA_W-1:0]  w_data;
    logic [3:0]         w_strb;
    logic               w_valid;
    logic               w_ready;
    logic [1:0]         b_resp;
    logic               b_valid;
    logic               b_ready;
    logic [ADDR_W-1:0]  ar_addr;
    logic [7:0]         ar_len;
    logic               ar_valid;
    logic               ar_ready;
    logic [DATA_W-1:0]  r_data;
    logic [1:0]         r_resp;
    logic               r_valid;
    logic               r_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .aw_addr   (aw_addr),
        .aw_len    (aw_len),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .b_resp    (b_resp),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_valid   (r_valid),
        .r_ready   (r_ready)
    );

    // One comparison: count it, report it on a single line.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly the accepting edge (DUT is in IDLE).
    task automatic send_cmd(input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait for rsp_valid with a cycle budget; expiry is a failed comparison.
    task automatic wait_rsp(input string tag, input int budget);
        int n;
        n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
    endtask

    // Idle every slave/local input.
    task automatic quiet();
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        b_resp    = 2'd0;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_data    = '0;
        r_resp    = 2'd0;
        rsp_ready = 1'b0;
    endtask

    // Skewed write: one channel's ready 4 cycles before the other's.
    task automatic skewed_write(input logic aw_first, input string tag);
        quiet();
        send_cmd(1'b1, 32'h40, 32'h0BAD_F00D, 4'h3);
        if (aw_first) aw_ready = 1'b1; else w_ready = 1'b1;
        tick();                                        // first handshake
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        check({tag, "_first_dropped"}, aw_first ? aw_valid : w_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_second_held"}, aw_first ? w_valid : aw_valid, 1'b1);
            check({tag, "_bready_low"}, b_ready, 1'b0);
            tick();
        end
        check({tag, "_second_payload"}, aw_first ? w_data : aw_addr,
              aw_first ? 64'h0BAD_F00D : 64'h40);
        if (aw_first) w_ready = 1'b1; else aw_ready = 1'b1;
        tick();                                        // second handshake, 4 later
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        check({tag, "_both_dropped"}, {aw_valid, w_valid}, 2'b00);
        check({tag, "_bready_up"}, b_ready, 1'b1);
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        check({tag, "_rsp"}, rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_one_rsp"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        quiet();
        tick();
        tick();
        rst = 1'b0;

        // ---------------- reset state
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_valids", {aw_valid, w_valid, ar_valid, rsp_valid}, 4'b0000);
        check("rst_readys", {b_ready, r_ready}, 2'b00);
        check("rst_rsp", {rsp_rdata, rsp_resp}, 34'd0);
        check("rst_payload", {aw_addr, ar_addr, w_data, w_strb}, 100'd0);

        // ---------------- write, all immediate; accept edge = N
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'd0;
        rsp_ready = 1'b0;
        send_cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);   // edge N
        check("wr_aw_valid", {aw_valid, w_valid}, 2'b11);
        check("wr_aw_addr", aw_addr, 32'h10);
        check("wr_w_data", w_data, 32'hDEAD_BEEF);
        check("wr_w_strb", w_strb, 4'hF);
        check("wr_aw_len", aw_len, 8'd0);
        check("wr_cmd_ready_low", cmd_ready, 1'b0);
        tick();                                        // N+1 AW/W handshake
        check("wr_bready", {b_ready, aw_valid, w_valid}, 3'b100);
        tick();                                        // N+2 B handshake
        check("wr_rsp_valid_n3", rsp_valid, 1'b1);
        check("wr_rsp", {rsp_rdata, rsp_resp}, 34'd0);
        check("wr_bready_drop", b_ready, 1'b0);
        rsp_ready = 1'b1;
        tick();                                        // N+3 rsp handshake
        check("wr_cmd_ready_n4", cmd_ready, 1'b1);
        quiet();

        // ---------------- read with delayed slave
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            check("rd_ar_held", {ar_valid, cmd_ready}, 2'b10);
            check("rd_ar_addr", ar_addr, 32'h10);
            check("rd_ar_len", ar_len, 8'd0);
            if (i == 2) ar_ready = 1'b1;
            if (i < 2) tick();
        end
        tick();                                        // AR handshake
        ar_ready = 1'b0;
        check("rd_ar_drop", {ar_valid, r_ready}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            check("rd_rready_wait", {r_ready, rsp_valid, cmd_ready}, 3'b100);
            if (i == 2) begin
                r_valid = 1'b1;
                r_data  = 32'hDEAD_BEEF;
                r_resp  = 2'd0;
            end
            if (i < 2) tick();
        end
        tick();                                        // R handshake
        r_valid = 1'b0;
        check("rd_rsp_valid", {rsp_valid, r_ready, cmd_ready}, 3'b100);
        check("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd_resp", rsp_resp, 2'd0);
        rsp_ready = 1'b1;
        tick();
        check("rd_idle", cmd_ready, 1'b1);
        quiet();

        // ---------------- skewed AW/W orders
        skewed_write(1'b0, "skew_w_first");
        skewed_write(1'b1, "skew_aw_first");

        // ---------------- error responses
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'd2;
        rsp_ready = 1'b1;
        send_cmd(1'b1, 32'h44, 32'h1, 4'h0);           // zero strobe still writes
        check("err_wr_zero_strb", {aw_valid, w_valid, w_strb}, 6'b110000);
        wait_rsp("err_wr", 10);
        check("err_wr_resp", rsp_resp, 2'd2);
        check("err_wr_rdata", rsp_rdata, 32'd0);
        tick();
        check("err_wr_idle", cmd_ready, 1'b1);
        quiet();
        ar_ready = 1'b1; r_valid = 1'b1; r_data = 32'h1234_5678; r_resp = 2'd3;
        rsp_ready = 1'b1;
        send_cmd(1'b0, 32'h0000_0003, 32'h0, 4'h0);    // unaligned passes through
        check("err_rd_addr", ar_addr, 32'h0000_0003);
        wait_rsp("err_rd", 10);
        check("err_rd_resp", rsp_resp, 2'd3);
        check("err_rd_rdata", rsp_rdata, 32'h1234_5678);
        tick();
        check("err_rd_idle", cmd_ready, 1'b1);
        quiet();

        // ---------------- response backpressure with a pending command
        ar_ready = 1'b1; r_valid = 1'b1; r_data = 32'hA5A5_0001; r_resp = 2'd1;
        send_cmd(1'b0, 32'h30, 32'h0, 4'h0);
        wait_rsp("bp_first", 10);
        r_data    = 32'hCAFE_F00D;                     // stray R must be ignored
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_held", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, 32'hA5A5_0001, 2'd1});
            check("bp_no_new_req", {cmd_ready, ar_valid, aw_valid, w_valid}, 4'b0000);
            tick();
        end
        rsp_ready = 1'b1;
        tick();                                        // rsp handshake
        rsp_ready = 1'b0;
        check("bp_idle", {cmd_ready, rsp_valid}, 2'b10);
        tick();                                        // pending command accepted
        cmd_valid = 1'b0;
        check("bp_next_ar", {ar_valid, ar_addr}, {1'b1, 32'h20});
        wait_rsp("bp_second", 10);
        check("bp_second_rdata", rsp_rdata, 32'hCAFE_F00D);
        rsp_ready = 1'b1;
        tick();
        quiet();

        // ---------------- reset during WR_REQ
        send_cmd(1'b1, 32'h80, 32'h7777_7777, 4'hF);
        check("mid_aw_valid", aw_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valids", {aw_valid, w_valid, ar_valid, rsp_valid}, 4'b0000);
        check("mid_rst_readys", {b_ready, r_ready, cmd_ready}, 3'b001);
        ar_ready = 1'b1; r_valid = 1'b1; r_data = 32'h5A5A_5A5A; r_resp = 2'd0;
        rsp_ready = 1'b1;
        send_cmd(1'b0, 32'h84, 32'h0, 4'h0);
        check("post_rst_ar", {ar_valid, ar_addr}, {1'b1, 32'h84});
        wait_rsp("post_rst", 10);
        check("post_rst_rdata", rsp_rdata, 32'h5A5A_5A5A);
        tick();
        check("post_rst_idle", cmd_ready, 1'b1);
        quiet();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
